// File: rtl/dims.sv
// Shared types for the matmul+GELU control path: run sequencer states and
// the dimension record used by the host register block.
package dims;

  localparam int unsigned DIM_W     = 16;
  localparam int unsigned RUN_CNT_W = 2 * DIM_W;

  typedef struct packed {
    logic [DIM_W-1:0] m1;
    logic [DIM_W-1:0] m3;
  } dim_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    NEXT,
    DONE
  } run_state_t;

endpackage

// File: rtl/stall_watchdog.sv
// Saturating stall counter: counts enabled cycles, flags when it reaches all-ones.
module stall_watchdog #(
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = (count == '1);

endmodule

// File: rtl/mm_gelu_run_ctrl.sv
// Per-run layer sequencer for the fused matmul+GELU datapath: steps layers,
// counts output beats per layer and reports tlast, stall and dimension errors.
module mm_gelu_run_ctrl
  import dims::*;
#(
  parameter  int unsigned LAYERS       = 12,
  parameter  int unsigned MATRIXSIZE_W = 16,
  parameter  int unsigned TIMEOUT_W    = 20,
  localparam int unsigned LAYER_W      = (LAYERS > 1) ? $clog2(LAYERS) : 1,
  localparam int unsigned CNT_W        = 2 * MATRIXSIZE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LAYER_W-1:0]      first_layer,
  input  logic [LAYER_W-1:0]      last_layer,
  input  logic [MATRIXSIZE_W-1:0] M1,
  input  logic [MATRIXSIZE_W-1:0] M3,
  input  logic                    dn_tready,
  input  logic                    mm_tvalid,
  input  logic                    mm_tlast,
  output logic                    mm_tready,
  output logic [LAYER_W-1:0]      layer,
  output logic                    in_en,
  output logic                    busy,
  output logic                    done,
  output logic                    err_tlast,
  output logic                    err_timeout,
  output logic                    err_dim,
  output logic [CNT_W-1:0]        beat_cnt
);

  run_state_t state;

  logic [LAYER_W-1:0]      first_q;
  logic [LAYER_W-1:0]      last_q;
  logic [MATRIXSIZE_W-1:0] m1_q;
  logic [MATRIXSIZE_W-1:0] m3_q;
  logic [CNT_W-1:0]        expected;
  logic [CNT_W-1:0]        product;

  logic hs;
  logic count_end;
  logic layer_end;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  assign mm_tready = dn_tready & (state == RUN);
  assign hs        = mm_tvalid & mm_tready;

  // Product only feeds the LOAD-cycle register, keeping the multiplier off RUN paths.
  assign product   = CNT_W'(m1_q) * CNT_W'(m3_q);

  assign count_end = (beat_cnt == expected - CNT_W'(1));
  assign layer_end = hs & (count_end | mm_tlast);

  assign wd_clear  = (state != RUN) | hs;
  assign wd_enable = (state == RUN) & ~hs;

  stall_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      first_q     <= '0;
      last_q      <= '0;
      m1_q        <= '0;
      m3_q        <= '0;
      expected    <= '0;
      layer       <= '0;
      beat_cnt    <= '0;
      in_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_tlast   <= 1'b0;
      err_timeout <= 1'b0;
      err_dim     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            first_q     <= first_layer;
            last_q      <= last_layer;
            m1_q        <= M1;
            m3_q        <= M3;
            beat_cnt    <= '0;
            err_tlast   <= 1'b0;
            err_timeout <= 1'b0;
            err_dim     <= 1'b0;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end

        LOAD: begin
          expected <= product;
          layer    <= first_q;
          if (product == '0 || first_q > last_q) begin
            err_dim <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            in_en <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          if (hs) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (layer_end) begin
              if (count_end != mm_tlast) begin
                err_tlast <= 1'b1;
              end
              in_en <= 1'b0;
              state <= NEXT;
            end
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
            in_en       <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end

        NEXT: begin
          beat_cnt <= '0;
          if (layer == last_q) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            layer <= layer + LAYER_W'(1);
            in_en <= 1'b1;
            state <= RUN;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_gelu_run_ctrl.sv
// Scoreboard bench for mm_gelu_run_ctrl: runs are described by range, dims
// and tlast position; a reference model queues expected beats and run results.
module tb_mm_gelu_run_ctrl;

  localparam int TW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  first_layer = '0;
  logic [3:0]  last_layer = '0;
  logic [15:0] M1 = '0;
  logic [15:0] M3 = '0;
  logic        dn_tready = 1'b0;
  logic        mm_tvalid = 1'b0;
  logic        mm_tlast = 1'b0;
  logic        mm_tready;
  logic [3:0]  layer;
  logic        in_en;
  logic        busy;
  logic        done;
  logic        err_tlast;
  logic        err_timeout;
  logic        err_dim;
  logic [31:0] beat_cnt;

  mm_gelu_run_ctrl #(
    .LAYERS      (12),
    .MATRIXSIZE_W(16),
    .TIMEOUT_W   (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_layer(first_layer),
    .last_layer (last_layer),
    .M1         (M1),
    .M3         (M3),
    .dn_tready  (dn_tready),
    .mm_tvalid  (mm_tvalid),
    .mm_tlast   (mm_tlast),
    .mm_tready  (mm_tready),
    .layer      (layer),
    .in_en      (in_en),
    .busy       (busy),
    .done       (done),
    .err_tlast  (err_tlast),
    .err_timeout(err_timeout),
    .err_dim    (err_dim),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     lyr;
    longint beat;
  } hs_exp_t;

  typedef struct {
    bit     e_tlast;
    bit     e_dim;
    bit     e_to;
    int     lyr;
    longint hs;
    int     en;
    int     lat;
  } run_exp_t;

  hs_exp_t  hs_q[$];
  run_exp_t run_q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: compares every handshake and every done pulse against the queues.
  initial begin
    longint  m_hs;
    int      m_en;
    int      m_start;
    hs_exp_t h;
    run_exp_t r;
    m_hs = 0;
    m_en = 0;
    m_start = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) continue;
      if (start && !busy) begin
        m_hs = 0;
        m_en = 0;
        m_start = cyc;
      end
      chk("tready_gate", mm_tready, dn_tready & in_en);
      if (in_en) m_en++;
      if (mm_tvalid && mm_tready) begin
        if (hs_q.size() == 0) begin
          fail_now("unexpected_handshake");
        end else begin
          h = hs_q.pop_front();
          chk("hs_layer", layer, h.lyr);
          chk("hs_beat_cnt", beat_cnt, h.beat);
        end
        m_hs++;
      end
      if (done) begin
        if (run_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          r = run_q.pop_front();
          chk("err_tlast", err_tlast, r.e_tlast);
          chk("err_dim", err_dim, r.e_dim);
          chk("err_timeout", err_timeout, r.e_to);
          chk("final_layer", layer, r.lyr);
          chk("run_handshakes", m_hs, r.hs);
          chk("busy_at_done", busy, 1);
          if (r.en >= 0) chk("in_en_cycles", m_en, r.en);
          if (r.lat >= 0) chk("done_latency", cyc - m_start, r.lat);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start(input int first, input int last, input int m1, input int m3);
    @(negedge clk);
    first_layer = 4'(first);
    last_layer  = 4'(last);
    M1          = 16'(m1);
    M3          = 16'(m3);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  // vmode: 0 always valid, 1 random, 2 never. rmode: 0 always ready, 1 toggle, 2 random.
  // tl_pos: beat index within a layer carrying tlast, -1 for never.
  task automatic run(input int first, input int last, input int m1, input int m3,
                     input int tl_pos, input int vmode, input int rmode);
    longint   e;
    longint   beats;
    longint   k;
    int       nl;
    int       streak;
    int       t;
    bit       seen_done;
    bit       dim_bad;
    run_exp_t r;

    e       = longint'(m1) * longint'(m3);
    dim_bad = (e == 0) || (first > last);
    r.e_tlast = 0;
    r.e_dim   = dim_bad;
    r.e_to    = 0;
    r.lyr     = first;
    r.hs      = 0;
    r.en      = -1;
    r.lat     = -1;
    if (dim_bad) begin
      r.en  = 0;
      r.lat = 2;
    end else if (vmode == 2) begin
      r.e_to = 1;
      r.en   = 2 ** TW;
      r.lat  = 2 + 2 ** TW;
    end else begin
      beats     = (tl_pos >= 0 && tl_pos < e) ? tl_pos + 1 : e;
      r.e_tlast = (tl_pos != e - 1);
      nl        = last - first + 1;
      for (int l = first; l <= last; l++)
        for (longint b = 0; b < beats; b++) hs_q.push_back('{lyr: l, beat: b});
      r.hs  = nl * beats;
      r.lyr = last;
      if (vmode == 0 && rmode == 0) begin
        r.en  = nl * int'(beats);
        r.lat = 2 + nl * (int'(beats) + 1);
      end
    end
    run_q.push_back(r);

    mm_tvalid = 1'b0;
    mm_tlast  = 1'b0;
    pulse_start(first, last, m1, m3);

    k = 0;
    streak = 0;
    seen_done = 0;
    t = 0;
    while (!seen_done && t < 5000) begin
      case (rmode)
        0:       dn_tready = 1'b1;
        1:       dn_tready = (t % 2 == 0);
        default: dn_tready = ($urandom_range(0, 3) != 0);
      endcase
      case (vmode)
        0:       mm_tvalid = 1'b1;
        1:       mm_tvalid = ($urandom_range(0, 3) != 0);
        default: mm_tvalid = 1'b0;
      endcase
      if (vmode != 2 && streak >= 8) begin
        dn_tready = 1'b1;
        mm_tvalid = 1'b1;
      end
      mm_tlast = (k == tl_pos);
      #2;
      if (mm_tvalid && mm_tready) begin
        streak = 0;
        if (k == tl_pos || k == e - 1) k = 0;
        else k++;
      end else if (in_en) begin
        streak++;
      end
      if (done) seen_done = 1;
      @(negedge clk);
      t++;
    end
    mm_tvalid = 1'b0;
    mm_tlast  = 1'b0;
    if (!seen_done) begin
      fail_now("done_never_seen");
      do_reset();
      hs_q.delete();
      run_q.delete();
    end else begin
      #2;
      chk("busy_after_done", busy, 0);
      chk("beats_left_in_queue", hs_q.size(), 0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_layer"}, layer, 0);
    chk({tag, "_beat_cnt"}, beat_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_en"}, in_en, 0);
    chk({tag, "_tready"}, mm_tready, 0);
    chk({tag, "_errs"}, {err_tlast, err_timeout, err_dim}, 0);
  endtask

  initial begin
    int n;
    int t;
    int f;
    int l;
    int m1;
    int m3;
    int tp;
    longint e;

    dn_tready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check_idle_outputs("reset");

    // Nominal, then backpressure, then tlast faults.
    run(0, 2, 4, 8, 31, 0, 0);
    run(0, 2, 4, 8, 31, 0, 1);
    run(0, 1, 2, 4, 5, 1, 2);
    run(0, 1, 2, 4, -1, 1, 2);

    // Bad configurations and stall.
    run(1, 2, 4, 0, 0, 0, 0);
    run(5, 3, 2, 2, 3, 0, 0);
    run(2, 4, 3, 3, 8, 2, 0);

    // Reset in the middle of RUN after five beats on layer 3.
    for (int b = 0; b < 5; b++) hs_q.push_back('{lyr: 3, beat: b});
    dn_tready = 1'b1;
    mm_tvalid = 1'b1;
    mm_tlast  = 1'b0;
    pulse_start(3, 5, 4, 4);
    n = 0;
    t = 0;
    while (n < 5 && t < 50) begin
      #2;
      if (mm_tvalid && mm_tready) n++;
      @(negedge clk);
      t++;
    end
    if (n < 5) fail_now("midrun_handshakes_missing");
    chk("pre_reset_beat_cnt", beat_cnt, 5);
    chk("pre_reset_layer", layer, 3);
    mm_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_idle_outputs("midrun_reset");
    hs_q.delete();
    run(3, 4, 2, 3, 5, 0, 0);

    // Randomized runs.
    for (int i = 0; i < 6; i++) begin
      f  = int'($urandom_range(0, 11));
      l  = f + int'($urandom_range(0, 2));
      if (l > 11) l = 11;
      m1 = int'($urandom_range(1, 4));
      m3 = int'($urandom_range(1, 4));
      e  = longint'(m1) * longint'(m3);
      case ($urandom_range(0, 2))
        0:       tp = int'(e) - 1;
        1:       tp = int'($urandom_range(0, 32'(e - 1)));
        default: tp = -1;
      endcase
      run(f, l, m1, m3, tp, 1, 2);
    end

    repeat (3) @(negedge clk);
    chk("runs_left_in_queue", run_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
